// File: rtl/reg_alu_ctrl_if.sv
// Instruction handshake plus reg_alu control/status bundle between upstream, reg_alu_ctrl and reg_alu.
// master = the environment that issues words and observes control; slave = reg_alu_ctrl itself.
interface reg_alu_ctrl_if;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        cout;
    logic        sel;
    logic        wr;
    logic [1:0]  op;
    logic [2:0]  rd_addr_a;
    logic [2:0]  rd_addr_b;
    logic [2:0]  wr_addr;
    logic [15:0] d_in;
    logic        halted;
    logic        carry_flag;

    modport master (
        output instr, instr_valid, cout,
        input  instr_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, halted, carry_flag
    );

    modport slave (
        input  instr, instr_valid, cout,
        output instr_ready, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in, halted, carry_flag
    );
endinterface

// File: rtl/reg_alu_ctrl.sv
// Decodes NOP/LDI/ALU/HALT words into one-cycle reg_alu write controls; CARRY_FLAG_EN adds a carry flag.
// Latency: controls are registered, wr is high for the single cycle after the opcode (ALU) or immediate (LDI) edge.
// Backpressure: instr_ready drops during the write cycle and permanently after HALT; upstream holds its word.
module reg_alu_ctrl (
    input  logic           clk,
    input  logic           reset,
    reg_alu_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, IMM, EXEC, HALT} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [1:0]  opc;
    logic [2:0]  rd_lat;
    logic        sel_q;
    logic        wr_q;
    logic [1:0]  op_q;
    logic [2:0]  rd_addr_a_q;
    logic [2:0]  rd_addr_b_q;
    logic [2:0]  wr_addr_q;
    logic [15:0] d_in_q;

    assign opc             = bus.instr[15:14];
    assign bus.instr_ready = (state == IDLE) || (state == IMM);
    assign accept          = bus.instr_valid && bus.instr_ready;
    assign bus.halted      = (state == HALT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (opc)
                        2'b01:   state_nxt = IMM;
                        2'b10:   state_nxt = EXEC;
                        2'b11:   state_nxt = HALT;
                        default: state_nxt = IDLE;
                    endcase
                end
            end
            IMM:     if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // wr defaults low every edge so it can only ever be a one-cycle pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_lat      <= '0;
            sel_q       <= 1'b0;
            wr_q        <= 1'b0;
            op_q        <= '0;
            rd_addr_a_q <= '0;
            rd_addr_b_q <= '0;
            wr_addr_q   <= '0;
            d_in_q      <= '0;
        end else begin
            wr_q <= 1'b0;
            if (accept && (state == IDLE) && (opc == 2'b01)) begin
                rd_lat <= bus.instr[13:11];
            end
            if (accept && (state == IDLE) && (opc == 2'b10)) begin
                sel_q       <= 1'b1;
                wr_q        <= 1'b1;
                op_q        <= bus.instr[13:12];
                rd_addr_a_q <= bus.instr[11:9];
                rd_addr_b_q <= bus.instr[8:6];
                wr_addr_q   <= bus.instr[5:3];
                d_in_q      <= '0;
            end else if (accept && (state == IMM)) begin
                sel_q     <= 1'b0;
                wr_q      <= 1'b1;
                wr_addr_q <= rd_lat;
                d_in_q    <= bus.instr;
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.wr        = wr_q;
    assign bus.op        = op_q;
    assign bus.rd_addr_a = rd_addr_a_q;
    assign bus.rd_addr_b = rd_addr_b_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.d_in      = d_in_q;

`ifdef CARRY_FLAG_EN
    logic carry_q;

    // sel_q is only high in EXEC for an ALU word, so this captures cout exactly at the end of that cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          carry_q <= 1'b0;
        else if ((state == EXEC) && sel_q)  carry_q <= bus.cout;
    end

    assign bus.carry_flag = carry_q;
`else
    logic unused_cout;

    assign unused_cout    = bus.cout;
    assign bus.carry_flag = 1'b0;
`endif

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Self-checking bench for reg_alu_ctrl: directed scenarios plus random traffic against an instruction-level model.
module tb_reg_alu_ctrl;

`ifdef CARRY_FLAG_EN
    localparam bit CF = 1'b1;
`else
    localparam bit CF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    reg_alu_ctrl_if bus();

    reg_alu_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // instruction-level model: what the control outputs must look like
    bit          m_halted, m_want_imm, m_busy, m_last_alu;
    logic [2:0]  m_rd;
    logic        e_sel, e_wr, e_halted, e_carry;
    logic [1:0]  e_op;
    logic [2:0]  e_ra, e_rb, e_wa;
    logic [15:0] e_din;

    logic [15:0] regfile [8];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          dut_acc_cnt = 0;
    int          wr_cycles[$];
    bit          got_acc = 1'b0;
    int          send_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_halted = 0; m_want_imm = 0; m_busy = 0; m_last_alu = 0; m_rd = '0;
        e_sel = 0; e_wr = 0; e_halted = 0; e_carry = 0;
        e_op = '0; e_ra = '0; e_rb = '0; e_wa = '0; e_din = '0;
    endtask

    task automatic check_outputs();
        check("sel",        bus.sel,        e_sel);
        check("wr",         bus.wr,         e_wr);
        check("op",         bus.op,         e_op);
        check("rd_addr_a",  bus.rd_addr_a,  e_ra);
        check("rd_addr_b",  bus.rd_addr_b,  e_rb);
        check("wr_addr",    bus.wr_addr,    e_wa);
        check("d_in",       bus.d_in,       e_din);
        check("halted",     bus.halted,     e_halted);
        check("carry_flag", bus.carry_flag, e_carry);
    endtask

    task automatic drive(input logic [15:0] w, input logic v);
        bus.instr       = w;
        bus.instr_valid = v;
    endtask

    // one clock: predict from the model, clock the DUT, compare
    task automatic cycle();
        bit rdy, acc;
        logic [15:0] w;
        w   = bus.instr;
        rdy = !m_halted && !m_busy;
        check("instr_ready", bus.instr_ready, rdy);
        got_acc = bus.instr_valid && bus.instr_ready;
        if (got_acc) dut_acc_cnt++;
        acc = bus.instr_valid && rdy;
        if (m_busy) begin
            e_wr = 0;
            if (CF && m_last_alu) e_carry = bus.cout;
            m_busy = 0;
        end else if (acc) begin
            if (m_want_imm) begin
                e_sel = 0; e_wr = 1; e_wa = m_rd; e_din = w;
                m_busy = 1; m_last_alu = 0; m_want_imm = 0;
            end else begin
                case (w[15:14])
                    2'b01: begin m_want_imm = 1; m_rd = w[13:11]; end
                    2'b10: begin
                        e_sel = 1; e_wr = 1; e_op = w[13:12];
                        e_ra = w[11:9]; e_rb = w[8:6]; e_wa = w[5:3]; e_din = '0;
                        m_busy = 1; m_last_alu = 1;
                    end
                    2'b11: m_halted = 1;
                    default: ;
                endcase
            end
        end
        e_halted = m_halted;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.wr) begin
            wr_cnt++;
            wr_cycles.push_back(cyc);
            if (!bus.sel) regfile[bus.wr_addr] = bus.d_in;
        end
        check_outputs();
    endtask

    // upstream holds the word until the DUT takes it, bounded by a cycle budget
    task automatic send(input logic [15:0] w);
        int n = 0;
        drive(w, 1'b1);
        do begin
            cycle();
            n++;
        end while (!got_acc && n < 20);
        check("send_accepted", got_acc, 1'b1);
        send_cycles = n;
        bus.instr_valid = 1'b0;
    endtask

    initial begin
        int acc0, wr0;
        logic [15:0] w;
        for (int i = 0; i < 8; i++) regfile[i] = '0;
        drive(16'h0000, 1'b0);
        bus.cout = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        check("reset_ready", bus.instr_ready, 1'b1);
        reset = 1'b0;

        // LDI r3, 0xCDEF; first accept on first edge after reset
        send(16'h5800);
        check("first_accept_cycles", send_cycles, 1);
        send(16'hCDEF);
        check("ldi_wr", bus.wr, 1'b1);
        check("ldi_sel", bus.sel, 1'b0);
        check("ldi_wr_addr", bus.wr_addr, 3'd3);
        check("ldi_d_in", bus.d_in, 16'hCDEF);
        cycle();
        check("ldi_r3", regfile[3], 16'hCDEF);

        // ALU op 00, a=1 b=5 d=2, carry out high
        bus.cout = 1'b1;
        send(16'h8350);
        check("alu_sel", bus.sel, 1'b1);
        check("alu_wr", bus.wr, 1'b1);
        check("alu_op", bus.op, 2'b00);
        check("alu_ra", bus.rd_addr_a, 3'd1);
        check("alu_rb", bus.rd_addr_b, 3'd5);
        check("alu_wa", bus.wr_addr, 3'd2);
        cycle();
        bus.cout = 1'b0;
        check("alu_carry", bus.carry_flag, CF);

        // back-to-back ALU words with valid held high
        wr_cycles.delete();
        send(16'h8350);
        send(16'h8350);
        check("bp_second_wait", send_cycles, 2);
        cycle();
        cycle();
        check("bp_wr_pulses", wr_cycles.size(), 2);
        if (wr_cycles.size() == 2)
            check("bp_wr_spacing", wr_cycles[1] - wr_cycles[0], 2);

        // reset during IMM discards the pending load
        send(16'h5800);
        reset = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("rst_async_ready", bus.instr_ready, 1'b1);
        #6.5;
        reset = 1'b0;
        wr_cycles.delete();
        send(16'h8350);
        check("rst_first_accept", send_cycles, 1);
        check("rst_decodes_alu", bus.sel, 1'b1);
        cycle();
        check("rst_wr_pulses", wr_cycles.size(), 1);

        // four NOPs back to back
        acc0 = dut_acc_cnt;
        wr0  = wr_cnt;
        drive(16'h0000, 1'b1);
        repeat (4) cycle();
        drive(16'h0000, 1'b0);
        check("nop_accepts", dut_acc_cnt - acc0, 4);
        check("nop_wr", wr_cnt - wr0, 0);

        // random traffic, HALT excluded from opcode positions
        repeat (400) begin
            if (!(bus.instr_valid && !got_acc)) begin
                w = 16'($urandom);
                if (!m_want_imm && w[15:14] == 2'b11) w[15] = 1'b0;
                drive(w, $urandom_range(0, 3) != 0);
            end
            bus.cout = 1'($urandom);
            cycle();
        end
        drive(16'h0000, 1'b0);
        repeat (3) cycle();

        // HALT is terminal
        send(16'hC000);
        check("halt_halted", bus.halted, 1'b1);
        check("halt_ready", bus.instr_ready, 1'b0);
        wr0  = wr_cnt;
        acc0 = dut_acc_cnt;
        drive(16'h8350, 1'b1);
        repeat (10) cycle();
        check("halt_no_wr", wr_cnt - wr0, 0);
        check("halt_no_accept", dut_acc_cnt - acc0, 0);
        check("halt_stays", bus.halted, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
